// File: rtl/datapath_run_ctrl_if.sv
// Control and status bundle between the run controller and the testbench or top level.
// The testbench drives the master side; the controller sits on the slave side.
interface datapath_run_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic             instr_valid;
    logic             core_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;
    logic [XLEN-1:0]  last_pc;

    modport master (
        output start, pc, instr, instr_valid,
        input  core_reset, running, done, timeout, halt_cause,
               cycle_count, instr_count, last_pc
    );

    modport slave (
        input  start, pc, instr, instr_valid,
        output core_reset, running, done, timeout, halt_cause,
               cycle_count, instr_count, last_pc
    );
endinterface

// File: rtl/datapath_run_ctrl.sv
// Run controller for the single-cycle RISC-V datapath: sequences the core reset, counts
// cycles and retired instructions, and ends the run on ECALL, PC self-loop or watchdog.
module datapath_run_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     CNT_W        = 32,
    parameter int unsigned     RESET_CYCLES = 3,
    parameter int unsigned     STALL_LIMIT  = 4,
    parameter int unsigned     MAX_CYCLES   = 1024,
    parameter logic [XLEN-1:0] HALT_INSTR   = 32'h00000073
) (
    input  logic               clock,
    input  logic               reset,
    datapath_run_ctrl_if.slave bus
);
    localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0]   CYCLE_LAST = CNT_W'(MAX_CYCLES);

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_ECALL = 2'd1;
    localparam logic [1:0] CAUSE_LOOP  = 2'd2;
    localparam logic [1:0] CAUSE_WDOG  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_RUN      = 3'd2,
        ST_DONE     = 3'd3,
        ST_TIMEOUT  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [HOLD_W-1:0]  hold_r;
    logic [STALL_W-1:0] stall_r;
    logic [STALL_W-1:0] stall_next_s;
    logic [XLEN-1:0]    prev_pc_r;
    logic               prev_valid_r;
    logic [CNT_W-1:0]   cycle_r;
    logic [CNT_W-1:0]   cycle_next_s;
    logic [CNT_W-1:0]   instr_cnt_r;
    logic [CNT_W-1:0]   instr_next_s;
    logic [1:0]         halt_cause_r;
    logic [XLEN-1:0]    last_pc_r;
    logic               core_reset_r;
    logic               running_r;
    logic               done_r;
    logic               timeout_r;
    logic               ecall_hit_s;
    logic               loop_hit_s;
    logic               wd_hit_s;
    logic               restart_s;

    // Per-cycle RUN bookkeeping and the three termination conditions.
    always_comb begin
        cycle_next_s = cycle_r + CNT_W'(1);
        if (bus.instr_valid) begin
            instr_next_s = instr_cnt_r + CNT_W'(1);
        end else begin
            instr_next_s = instr_cnt_r;
        end
        // prev_valid_r keeps the first RUN cycle from matching a stale PC.
        if (prev_valid_r && (bus.pc == prev_pc_r)) begin
            stall_next_s = stall_r + STALL_W'(1);
        end else begin
            stall_next_s = '0;
        end
        ecall_hit_s = bus.instr_valid && (bus.instr == HALT_INSTR);
        loop_hit_s  = (stall_next_s == STALL_LAST);
        wd_hit_s    = (cycle_next_s == CYCLE_LAST);
        restart_s   = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                    (state_r == ST_TIMEOUT));
    end

    // Next-state selection; ECALL and self-loop outrank the watchdog.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (restart_s) begin
                    state_next_s = ST_RST_HOLD;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RST_HOLD: begin
                if (hold_r == HOLD_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_RST_HOLD;
                end
            end
            ST_RUN: begin
                if (ecall_hit_s || loop_hit_s) begin
                    state_next_s = ST_DONE;
                end else if (wd_hit_s) begin
                    state_next_s = ST_TIMEOUT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters, capture registers and flags, all registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_r       <= '0;
            stall_r      <= '0;
            prev_pc_r    <= '0;
            prev_valid_r <= 1'b0;
            cycle_r      <= '0;
            instr_cnt_r  <= '0;
            halt_cause_r <= CAUSE_NONE;
            last_pc_r    <= '0;
            core_reset_r <= 1'b1;
            running_r    <= 1'b0;
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            core_reset_r <= (state_next_s != ST_RUN);
            running_r    <= (state_next_s == ST_RUN);
            done_r       <= (state_next_s == ST_DONE);
            timeout_r    <= (state_next_s == ST_TIMEOUT);
            if (restart_s) begin
                hold_r       <= '0;
                stall_r      <= '0;
                prev_pc_r    <= '0;
                prev_valid_r <= 1'b0;
                cycle_r      <= '0;
                instr_cnt_r  <= '0;
                halt_cause_r <= CAUSE_NONE;
                last_pc_r    <= '0;
            end else if (state_r == ST_RST_HOLD) begin
                hold_r <= hold_r + HOLD_W'(1);
            end else if (state_r == ST_RUN) begin
                cycle_r      <= cycle_next_s;
                instr_cnt_r  <= instr_next_s;
                stall_r      <= stall_next_s;
                prev_pc_r    <= bus.pc;
                prev_valid_r <= 1'b1;
                if (ecall_hit_s) begin
                    halt_cause_r <= CAUSE_ECALL;
                    last_pc_r    <= bus.pc;
                end else if (loop_hit_s) begin
                    halt_cause_r <= CAUSE_LOOP;
                    last_pc_r    <= bus.pc;
                end else if (wd_hit_s) begin
                    halt_cause_r <= CAUSE_WDOG;
                    last_pc_r    <= bus.pc;
                end else begin
                    halt_cause_r <= halt_cause_r;
                    last_pc_r    <= last_pc_r;
                end
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    assign bus.core_reset  = core_reset_r;
    assign bus.running     = running_r;
    assign bus.done        = done_r;
    assign bus.timeout     = timeout_r;
    assign bus.halt_cause  = halt_cause_r;
    assign bus.cycle_count = cycle_r;
    assign bus.instr_count = instr_cnt_r;
    assign bus.last_pc     = last_pc_r;
endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Randomised bench for datapath_run_ctrl: a program-level reference model predicts each
// run's outcome into a scoreboard that a negedge monitor drains on every termination.
module tb_datapath_run_ctrl;
    localparam int XLEN = 32;
    localparam int CNT_W = 32;
    localparam int RCYC = 3;
    localparam int SLIM = 4;
    localparam int MAXC = 16;
    localparam logic [31:0] HALT = 32'h00000073;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] cyc;
        logic [31:0] icnt;
        logic [31:0] lpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic term_prev = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] prog_pc    [MAXC];
    logic [31:0] prog_instr [MAXC];
    logic        prog_valid [MAXC];

    always #5 clk = ~clk;

    datapath_run_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    datapath_run_ctrl #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RESET_CYCLES(RCYC), .STALL_LIMIT(SLIM),
        .MAX_CYCLES(MAXC), .HALT_INSTR(HALT)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Outcome of a run: the first RUN cycle that ends it, judged from the whole program.
    function automatic exp_t model();
        exp_t e;
        int   icnt;
        bit   same;
        bit   found;
        logic [1:0] cause;
        e.cause = 2'd0; e.cyc = 32'd0; e.icnt = 32'd0; e.lpc = 32'd0;
        icnt = 0;
        found = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            if (prog_valid[k]) icnt++;
            same = (k >= SLIM - 1);
            for (int j = 1; j < SLIM; j++) begin
                if (same && (prog_pc[k - j] != prog_pc[k])) same = 1'b0;
            end
            if (prog_valid[k] && prog_instr[k] == HALT) cause = 2'd1;
            else if (same)                             cause = 2'd2;
            else if (k == MAXC - 1)                    cause = 2'd3;
            else                                       cause = 2'd0;
            if (!found && cause != 2'd0) begin
                found  = 1'b1;
                e.cause = cause;
                e.cyc   = 32'(k + 1);
                e.icnt  = 32'(icnt);
                e.lpc   = prog_pc[k];
            end
        end
        return e;
    endfunction

    task automatic build_random(input int mode);
        int base;
        int s;
        int d;
        base = 4 * $urandom_range(0, 255);
        for (int k = 0; k < MAXC; k++) begin
            prog_pc[k]    = 32'(base + 4 * k);
            prog_instr[k] = $urandom;
            if (prog_instr[k] == HALT) prog_instr[k] = 32'h00000013;
            prog_valid[k] = ($urandom_range(0, 3) != 0);
        end
        s = $urandom_range(0, MAXC - 1);
        d = $urandom_range(0, MAXC - 1);
        case (mode)
            0: begin
                // A non-retiring HALT word is a decoy and must not stop the run.
                prog_instr[d] = HALT; prog_valid[d] = 1'b0;
                prog_instr[s] = HALT; prog_valid[s] = 1'b1;
            end
            1: for (int k = s; k < MAXC; k++) prog_pc[k] = prog_pc[s];
            2: ;
            default: begin
                for (int k = 0; k < MAXC; k++) begin
                    prog_pc[k] = 32'(base + 4 * $urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) prog_instr[k] = HALT;
                end
            end
        endcase
    endtask

    task automatic build_directed(input int which);
        for (int k = 0; k < MAXC; k++) begin
            prog_pc[k]    = 32'(4 * k);
            prog_instr[k] = 32'h00000013;
            prog_valid[k] = 1'b1;
        end
        case (which)
            0: prog_instr[5] = HALT;
            1: for (int k = 8; k < MAXC; k++) prog_pc[k] = 32'h20;
            3: prog_instr[MAXC - 1] = HALT;
            4: for (int k = 12; k < MAXC; k++) prog_pc[k] = 32'h30;
            default: ;
        endcase
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_core_reset"}, 32'(bus.core_reset), 32'd1);
        chk({name, "_running"}, 32'(bus.running), 32'd0);
        chk({name, "_done"}, 32'(bus.done), 32'd0);
        chk({name, "_timeout"}, 32'(bus.timeout), 32'd0);
        chk({name, "_cause"}, 32'(bus.halt_cause), 32'd0);
        chk({name, "_cycles"}, bus.cycle_count, 32'd0);
        chk({name, "_instrs"}, bus.instr_count, 32'd0);
        chk({name, "_last_pc"}, bus.last_pc, 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse (or hold) start, then expect exactly RCYC core-reset cycles before RUN.
    task automatic start_and_hold(input logic hold_start);
        int hold;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        hold = 0;
        while (!bus.running && hold < 12) begin
            chk("hold_core_reset", 32'(bus.core_reset), 32'd1);
            hold++;
            @(negedge clk);
        end
        chk("hold_cycles", 32'(hold), 32'(RCYC));
        chk("run_core_reset", 32'(bus.core_reset), 32'd0);
        chk("run_start_cycles", bus.cycle_count, 32'd0);
        chk("run_start_instrs", bus.instr_count, 32'd0);
        chk("run_start_cause", 32'(bus.halt_cause), 32'd0);
    endtask

    task automatic run_program(input logic hold_start);
        exp_t e;
        int   k;
        int   idx;
        e = model();
        sb_q.push_back(e);
        start_and_hold(hold_start);
        k = 0;
        while (bus.running && k < MAXC + 2) begin
            idx = (k < MAXC) ? k : MAXC - 1;
            bus.pc = prog_pc[idx];
            bus.instr = prog_instr[idx];
            bus.instr_valid = prog_valid[idx];
            @(negedge clk);
            k++;
        end
        chk("run_ended", 32'(bus.running), 32'd0);
        chk("run_length", 32'(k), e.cyc);
        if (hold_start) begin
            @(negedge clk);
            chk("restart_done", 32'(bus.done | bus.timeout), 32'd0);
            chk("restart_cycles", bus.cycle_count, 32'd0);
            chk("restart_core_reset", 32'(bus.core_reset), 32'd1);
            bus.start = 1'b0;
        end else begin
            repeat (3) begin
                bus.pc = $urandom; bus.instr = HALT; bus.instr_valid = 1'b1;
                @(negedge clk);
            end
            chk("sticky_done", 32'(bus.done), 32'(e.cause != 2'd3));
            chk("sticky_timeout", 32'(bus.timeout), 32'(e.cause == 2'd3));
            chk("sticky_cause", 32'(bus.halt_cause), 32'(e.cause));
            chk("sticky_cycles", bus.cycle_count, e.cyc);
            chk("sticky_instrs", bus.instr_count, e.icnt);
            chk("sticky_last_pc", bus.last_pc, e.lpc);
        end
    endtask

    // Scoreboard monitor: every new termination pops one predicted outcome.
    always @(negedge clk) begin
        if ((bus.done || bus.timeout) && !term_prev) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_end: actual cause %0d required no termination",
                         bus.halt_cause);
            end else begin
                mon_e = sb_q.pop_front();
                chk("mon_done", 32'(bus.done), 32'(mon_e.cause != 2'd3));
                chk("mon_timeout", 32'(bus.timeout), 32'(mon_e.cause == 2'd3));
                chk("mon_cause", 32'(bus.halt_cause), 32'(mon_e.cause));
                chk("mon_cycles", bus.cycle_count, mon_e.cyc);
                chk("mon_instrs", bus.instr_count, mon_e.icnt);
                chk("mon_last_pc", bus.last_pc, mon_e.lpc);
                chk("mon_core_reset", 32'(bus.core_reset), 32'd1);
                chk("mon_running", 32'(bus.running), 32'd0);
            end
        end
        term_prev <= bus.done || bus.timeout;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual simulation still running required finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pc = 32'd0;
        bus.instr = 32'd0;
        bus.instr_valid = 1'b0;
        do_reset(2);
        check_reset_vals("por");
        repeat (10) begin
            bus.pc = $urandom; bus.instr = $urandom; bus.instr_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_reset_vals("idle10");

        for (int t = 0; t < 5; t++) begin
            build_directed(t);
            run_program(1'b0);
        end

        // Reset partway into RUN, with start asserted at the same time.
        build_directed(2);
        start_and_hold(1'b0);
        for (int k = 0; k < 7; k++) begin
            bus.pc = prog_pc[k]; bus.instr = prog_instr[k]; bus.instr_valid = prog_valid[k];
            @(negedge clk);
        end
        chk("midrun_cycles", bus.cycle_count, 32'd7);
        chk("midrun_instrs", bus.instr_count, 32'd7);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check_reset_vals("midrun_rst");
        repeat (6) @(negedge clk);
        chk("rst_over_start", 32'(bus.running), 32'd0);

        // Reset while the core reset is still being held.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("hold_rst");
        repeat (6) @(negedge clk);
        chk("hold_rst_idle", 32'(bus.running), 32'd0);

        for (int r = 0; r < 40; r++) begin
            build_random($urandom_range(0, 3));
            run_program(1'b0);
        end

        build_random(0);
        run_program(1'b1);
        do_reset(1);
        check_reset_vals("final_rst");

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
